// File: rtl/param_counter_register_if.sv
// Command/data bundle between a datapath controller and one counter/register.
// Latency: none; pure signal grouping.
// Backpressure: none; commands are sampled on every edge by the register.
interface param_counter_register_if #(
  parameter int WIDTH     = 12,
  parameter int BUS_WIDTH = 16
);
  logic                 load;
  logic                 inc;
  logic                 dec;
  logic                 clr;
  logic [BUS_WIDTH-1:0] indata;
  logic [WIDTH-1:0]     outdata;
  logic                 carry;
  logic                 zero;
  logic                 cmd_error;

  // Controller side: issues commands and bus data, observes register state.
  modport master (
    output load, inc, dec, clr, indata,
    input  outdata, carry, zero, cmd_error
  );

  // Register side: consumes commands, presents contents and flags.
  modport slave (
    input  load, inc, dec, clr, indata,
    output outdata, carry, zero, cmd_error
  );
endinterface

// File: rtl/param_counter_register.sv
// Load/clear/inc/dec register with wrap or saturate, carry pulse, zero and sticky conflict flags.
// Latency: 1 clock from command to new contents; zero flag is combinational from contents.
// Backpressure: none; every command is accepted on the edge it is presented.
module param_counter_register #(
  parameter int               WIDTH       = 12,
  parameter int               BUS_WIDTH   = 16,
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                     clk,
  input logic                     reset,
  param_counter_register_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_value;
  logic             r_carry;
  logic             r_cmd_error;

  logic             w_inc_eff;
  logic             w_dec_eff;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_overflow;
  logic [2:0]       w_cmd_cnt;
  logic             w_multi_cmd;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;

  // clr and load both override counting; inc together with dec cancels out.
  assign w_inc_eff  = bus.inc & ~bus.dec & ~bus.clr & ~bus.load;
  assign w_dec_eff  = bus.dec & ~bus.inc & ~bus.clr & ~bus.load;
  assign w_at_max   = (r_value == ALL_ONES);
  assign w_at_zero  = (r_value == '0);
  // Boundary hit by an effective step; reported in both wrap and saturate modes.
  assign w_overflow = (w_inc_eff & w_at_max) | (w_dec_eff & w_at_zero);

  assign w_cmd_cnt   = 3'(bus.load) + 3'(bus.inc) + 3'(bus.dec) + 3'(bus.clr);
  assign w_multi_cmd = (w_cmd_cnt >= 3'd2);

  // Upper bus bits never reach the register.
  assign w_load_val = bus.indata[WIDTH-1:0];

  // Next-value selection in priority order clr > load > inc/dec.
  always_comb begin
    w_next = r_value;
    if (bus.clr) begin
      w_next = '0;
    end else if (bus.load) begin
      w_next = w_load_val;
    end else if (w_inc_eff) begin
      if (SATURATE && w_at_max) w_next = r_value;
      else                      w_next = r_value + ONE;
    end else if (w_dec_eff) begin
      if (SATURATE && w_at_zero) w_next = r_value;
      else                       w_next = r_value - ONE;
    end
  end

  // Register contents; reset forces the configured start value immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_value <= RESET_VALUE;
    else       r_value <= w_next;
  end

  // Carry is a one-cycle pulse, re-evaluated every edge so back-to-back hits stay high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_carry <= 1'b0;
    else       r_carry <= w_overflow;
  end

  // Command-conflict flag latches until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_cmd_error <= 1'b0;
    else if (w_multi_cmd) r_cmd_error <= 1'b1;
  end

  assign bus.outdata   = r_value;
  assign bus.carry     = r_carry;
  assign bus.zero      = (r_value == '0);
  assign bus.cmd_error = r_cmd_error;

endmodule
